// File: rtl/window_gen_3x3.sv
// Raster pixel stream to 3x3 interior-window generator with two line buffers.
// Optional macro WINDOW_CENTER_EN adds the centre output pixel_5_bin.
module window_gen_3x3 #(
   parameter int unsigned IMG_WIDTH  = 64,
   parameter int unsigned IMG_HEIGHT = 64,
   parameter int unsigned PIX_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   input  logic             sof,
   output logic [PIX_W-1:0] pixel_1_bin,
   output logic [PIX_W-1:0] pixel_2_bin,
   output logic [PIX_W-1:0] pixel_3_bin,
   output logic [PIX_W-1:0] pixel_4_bin,
`ifdef WINDOW_CENTER_EN
   output logic [PIX_W-1:0] pixel_5_bin,
`endif
   output logic [PIX_W-1:0] pixel_6_bin,
   output logic [PIX_W-1:0] pixel_7_bin,
   output logic [PIX_W-1:0] pixel_8_bin,
   output logic [PIX_W-1:0] pixel_9_bin,
   output logic             start,
   output logic             frame_done,
   output logic             busy
);

   localparam int unsigned COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

   generate
      if (IMG_WIDTH < 3) begin : g_bad_width
         $error("window_gen_3x3: IMG_WIDTH must be >= 3");
      end
      if (IMG_HEIGHT < 3) begin : g_bad_height
         $error("window_gen_3x3: IMG_HEIGHT must be >= 3");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FILL   = 2'd1,
      S_STREAM = 2'd2
   } state_t;

   state_t r_state;
   logic [ROW_W-1:0] r_row;
   logic [COL_W-1:0] r_col;

   // Column slices: [2]=top, [1]=mid, [0]=bottom
   logic [2:0][PIX_W-1:0] r_colb;
   logic [2:0][PIX_W-1:0] r_colc;

   logic [PIX_W-1:0] r_lb1 [IMG_WIDTH];
   logic [PIX_W-1:0] r_lb2 [IMG_WIDTH];

   logic [PIX_W-1:0] r_p1, r_p2, r_p3, r_p4, r_p6, r_p7, r_p8, r_p9;
`ifdef WINDOW_CENTER_EN
   logic [PIX_W-1:0] r_p5;
`endif
   logic r_start;
   logic r_frame_done;
   logic r_busy;

   logic                  w_accept;
   logic [ROW_W-1:0]      w_row;
   logic [COL_W-1:0]      w_col;
   logic [2:0][PIX_W-1:0] w_cur;
   logic                  w_eol;
   logic                  w_last;
   logic                  w_emit;

   // sof relocates the accepted pixel to (0,0) regardless of the counters
   assign w_accept = pix_valid & (sof | (r_state != S_IDLE));
   assign w_row    = sof ? '0 : r_row;
   assign w_col    = sof ? '0 : r_col;
   assign w_cur    = {r_lb2[w_col], r_lb1[w_col], pix_in};
   assign w_eol    = (w_col == COL_W'(IMG_WIDTH - 1));
   assign w_last   = w_eol && (w_row == ROW_W'(IMG_HEIGHT - 1));
   assign w_emit   = w_accept && (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));

   // Line buffers: read-before-write, contents only consumed from row 2 onward
   always_ff @(posedge clk) begin
      if (!reset && w_accept) begin
         r_lb2[w_col] <= r_lb1[w_col];
         r_lb1[w_col] <= pix_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_row        <= '0;
         r_col        <= '0;
         r_colb       <= '0;
         r_colc       <= '0;
         r_p1         <= '0;
         r_p2         <= '0;
         r_p3         <= '0;
         r_p4         <= '0;
         r_p6         <= '0;
         r_p7         <= '0;
         r_p8         <= '0;
         r_p9         <= '0;
`ifdef WINDOW_CENTER_EN
         r_p5         <= '0;
`endif
         r_start      <= 1'b0;
         r_frame_done <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_start      <= 1'b0;
         r_frame_done <= 1'b0;
         if (w_accept) begin
            r_colb  <= r_colc;
            r_colc  <= w_cur;
            r_start <= w_emit;
            // The current pixel's column is the right-hand column of the window
            if (w_emit) begin
               r_p1 <= r_colb[2];
               r_p4 <= r_colb[1];
               r_p7 <= r_colb[0];
               r_p2 <= r_colc[2];
               r_p8 <= r_colc[0];
               r_p3 <= w_cur[2];
               r_p6 <= w_cur[1];
               r_p9 <= w_cur[0];
`ifdef WINDOW_CENTER_EN
               r_p5 <= r_colc[1];
`endif
            end
            if (w_last) begin
               r_state      <= S_IDLE;
               r_row        <= '0;
               r_col        <= '0;
               r_frame_done <= 1'b1;
               r_busy       <= 1'b0;
            end else begin
               r_busy <= 1'b1;
               r_col  <= w_eol ? '0 : w_col + COL_W'(1);
               r_row  <= w_eol ? w_row + ROW_W'(1) : w_row;
               if (sof) begin
                  r_state <= S_FILL;
               end else if (w_eol && (w_row == ROW_W'(1))) begin
                  r_state <= S_STREAM;
               end
            end
         end
      end
   end

   assign pixel_1_bin = r_p1;
   assign pixel_2_bin = r_p2;
   assign pixel_3_bin = r_p3;
   assign pixel_4_bin = r_p4;
`ifdef WINDOW_CENTER_EN
   assign pixel_5_bin = r_p5;
`endif
   assign pixel_6_bin = r_p6;
   assign pixel_7_bin = r_p7;
   assign pixel_8_bin = r_p8;
   assign pixel_9_bin = r_p9;
   assign start       = r_start;
   assign frame_done  = r_frame_done;
   assign busy        = r_busy;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed scoreboard bench for window_gen_3x3 on a 4x4 ramp frame.
module tb_window_gen_3x3;

   localparam int unsigned W  = 4;
   localparam int unsigned H  = 4;
   localparam int unsigned PW = 8;

   typedef logic [8:0][PW-1:0] win_t; // entry k is pixel_(k+1)

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [PW-1:0] pix_in = '0;
   logic          pix_valid = 1'b0;
   logic          sof = 1'b0;
   logic [PW-1:0] p1, p2, p3, p4, p6, p7, p8, p9;
`ifdef WINDOW_CENTER_EN
   logic [PW-1:0] p5;
`endif
   logic          start, frame_done, busy;

   int   n_assert = 0;
   int   n_fail   = 0;
   int   n_start  = 0;
   win_t q[$];
   win_t last_exp = '0;

   window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
      .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
      .pixel_1_bin(p1), .pixel_2_bin(p2), .pixel_3_bin(p3), .pixel_4_bin(p4),
`ifdef WINDOW_CENTER_EN
      .pixel_5_bin(p5),
`endif
      .pixel_6_bin(p6), .pixel_7_bin(p7), .pixel_8_bin(p8), .pixel_9_bin(p9),
      .start(start), .frame_done(frame_done), .busy(busy)
   );

   always #5 clk = ~clk;

   // Window completed by ramp pixel (r,c): rows r-2..r, cols c-2..c
   function automatic win_t ramp_win(input int base, input int r, input int c);
      win_t w;
      for (int k = 0; k < 9; k++) begin
         w[k] = PW'(base + (r - 2 + k / 3) * int'(W) + (c - 2 + k % 3));
      end
      return w;
   endfunction

   function automatic win_t mask(input win_t w);
      win_t m = w;
`ifndef WINDOW_CENTER_EN
      m[4] = '0;
`endif
      return m;
   endfunction

   function automatic win_t obs_win();
      win_t w;
      w[0] = p1; w[1] = p2; w[2] = p3; w[3] = p4;
`ifdef WINDOW_CENTER_EN
      w[4] = p5;
`else
      w[4] = '0;
`endif
      w[5] = p6; w[6] = p7; w[7] = p8; w[8] = p9;
      return w;
   endfunction

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus; outputs sampled 1 time unit after the edge
   task automatic step(input logic v, input logic s, input logic [PW-1:0] p,
                       input logic es, input logic efd);
      win_t e;
      @(negedge clk);
      pix_valid = v; sof = s; pix_in = p;
      @(posedge clk);
      #1;
      chk("start", 72'(start), 72'(es));
      chk("frame_done", 72'(frame_done), 72'(efd));
      if (start) begin
         n_start++;
         n_assert++;
         assert (q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_window observed=start expected=no_start");
         end
         if (q.size() != 0) begin
            e = q.pop_front();
            last_exp = e;
            chk("window", obs_win(), mask(e));
         end
      end else begin
         chk("hold", obs_win(), mask(last_exp));
      end
   endtask

   // Drive the first npix pixels of a ramp frame, optionally with 1-0-1 gaps
   task automatic drive_frame(input int base, input bit gaps, input int npix);
      int r, c;
      logic es, efd;
      for (int i = 0; i < npix; i++) begin
         r   = i / int'(W);
         c   = i % int'(W);
         es  = (r >= 2) && (c >= 2);
         efd = (i == int'(W * H) - 1);
         if (es) q.push_back(ramp_win(base, r, c));
         step(1'b1, (i == 0), PW'(base + i), es, efd);
         if (i == 0) chk("busy_in_frame", 72'(busy), 72'(1));
         if (efd) chk("busy_after_frame", 72'(busy), 72'(0));
         if (gaps && !efd) step(1'b0, 1'b0, 8'hEE, 1'b0, 1'b0);
      end
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", obs_win(), '0);
      chk("reset_start", 72'(start), 72'(0));
      chk("reset_busy", 72'(busy), 72'(0));
      @(negedge clk);
      reset = 1'b0;

      // Continuous ramp frame
      n_start = 0;
      drive_frame(0, 1'b0, 16);
      chk("count_ramp", 72'(n_start), 72'(4));
      chk("last_window", obs_win(), mask(ramp_win(0, 3, 3)));
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      // Same ramp with valid gaps
      n_start = 0;
      drive_frame(0, 1'b1, 16);
      chk("count_gaps", 72'(n_start), 72'(4));

      // Valid pixels without sof in IDLE are dropped
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, PW'(200 + i), 1'b0, 1'b0);
      chk("idle_busy", 72'(busy), 72'(0));
      n_start = 0;
      drive_frame(0, 1'b0, 16);
      chk("count_after_drop", 72'(n_start), 72'(4));

      // sof restart at (row 2, col 1) with ramp +100
      n_start = 0;
      drive_frame(0, 1'b0, 9);
      drive_frame(100, 1'b0, 16);
      chk("count_restart", 72'(n_start), 72'(4));

      // Reset at (row 2, col 2) together with a valid pixel
      drive_frame(0, 1'b0, 10);
      @(negedge clk);
      pix_valid = 1'b1; sof = 1'b0; pix_in = 8'd10; reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_reset_start", 72'(start), 72'(0));
      chk("mid_reset_outputs", obs_win(), '0);
      chk("mid_reset_busy", 72'(busy), 72'(0));
      chk("mid_reset_fd", 72'(frame_done), 72'(0));
      last_exp = '0;
      @(negedge clk);
      reset = 1'b0; pix_valid = 1'b0;
      n_start = 0;
      drive_frame(0, 1'b0, 16);
      chk("count_after_reset", 72'(n_start), 72'(4));

      // Back-to-back frames
      n_start = 0;
      drive_frame(0, 1'b0, 16);
      drive_frame(50, 1'b0, 16);
      chk("count_b2b", 72'(n_start), 72'(8));
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      chk("queue_drained", 72'(q.size()), 72'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Upstream neighbour of the edge-detect core: converts a raster-order 8-bit pixel stream into 3x3 neighbourhood windows.
- Each window is presented on pixel_1_bin..pixel_9_bin with a one-cycle start pulse.
- Holds two line buffers of IMG_WIDTH pixels plus a 3-column shift window.
- Emits only fully-interior windows, with no border padding.

Parameters:
- IMG_WIDTH, 64: pixels per line; must be >= 3 (elaboration-time $error otherwise).
- IMG_HEIGHT, 64: lines per frame; must be >= 3.
- PIX_W, 8: pixel width in bits.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pix_in  in  PIX_W  incoming pixel, raster order.
- pix_valid  in  1  pix_in is valid this cycle; no backpressure, and gaps are allowed.
- sof  in  1  start of frame; qualified by pix_valid, marks pixel (row 0, col 0).
- pixel_1_bin .. pixel_4_bin, pixel_6_bin .. pixel_9_bin  out  PIX_W each  window: 1/2/3 top row L..R, 4/6 middle row L/R, 7/8/9 bottom row L..R.
- start  out  1  one-cycle pulse: window outputs are valid this cycle.
- frame_done  out  1  one-cycle pulse, one cycle after the last pixel of the frame is accepted.
- busy  out  1  high while in FILL or STREAM.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high.
- Reset: state=IDLE, row=col=0, all pixel outputs=0, start=0, frame_done=0, busy=0, window shift registers=0. Line buffer RAM is not reset; its contents are don't-care because of row gating.
- Accept: a pixel is accepted when pix_valid=1 and state!=IDLE, or when pix_valid&sof=1 in any state.
- Pixels with pix_valid=1, sof=0 in IDLE are dropped.
- Counters: col runs 0..IMG_WIDTH-1. On an accepted pixel at col=IMG_WIDTH-1, col wraps to 0 and row increments.
- sof always forces the accepted pixel to (0,0) and state=FILL. A sof mid-frame restarts the frame with no frame_done.
- Line buffers, per accepted pixel at column c:
  - top = lb2[c], mid = lb1[c], bot = pix_in.
  - Writes: lb2[c] <= lb1[c], lb1[c] <= pix_in.
  - Single-port read-before-write per address; this is synthesisable as RAM or registers.
- Window shift on each accepted pixel:
  - colA <= colB, colB <= colC, colC <= {top, mid, bot}.
  - Columns are PIX_W x 3 registers.
- Output: on an accepted pixel with row>=2 and col>=2, the registered outputs update next cycle and start=1 that cycle:
  - pixel_1/4/7 = previous colB (two columns back).
  - pixel_2/(5)/8 = previous colC.
  - pixel_3/6/9 = {top, mid, bot} of the current pixel.
  - The window centre is (row-1, col-1).
  - Latency: start asserts exactly 1 cycle after the completing pixel is accepted.
- Outputs hold their last window between start pulses; start=0 otherwise.
- State machine:
  - IDLE -> FILL on an accepted sof.
  - FILL (rows 0,1, no start) -> STREAM when row becomes 2.
  - STREAM -> IDLE after accepting (IMG_HEIGHT-1, IMG_WIDTH-1), pulsing frame_done next cycle.
  - sof in any state -> FILL.
- Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2). The first two columns of every row never produce start, so there is no wrap-across-line windows.
- pix_valid gaps freeze counters, line buffers and window; outputs hold.
- A reset asserted mid-frame takes priority over all inputs that cycle and returns to the reset state. No start or frame_done is produced on the cycle after reset.

Optional Feature:
- Macro: WINDOW_CENTER_EN.
- Defined: adds output port pixel_5_bin (PIX_W) carrying the centre pixel (mid of previous colC). Its reset and update timing are identical to the other outputs.
- Undefined: no pixel_5_bin port and no storage dedicated to it; the middle entry of colC remains because later windows need it as pixel_4. The interface then matches the 8-neighbour consumer.

Test Plan:
- Ramp, IMG_WIDTH=IMG_HEIGHT=4, pix=row*4+col, continuous valid, sof on pixel 0 -> exactly 4 start pulses.
  - First pulse 1 cycle after pix=10 accepted, with pixel_1..9 = 0,1,2,4,(5),6,8,9,10.
  - Last window = 5,6,7,9,(10),11,13,14,15.
  - frame_done pulses 1 cycle after pix=15.
- Same ramp with pix_valid toggling 1-0-1 -> identical window values and count of 4; start spacing follows accepted pixels, and outputs hold during gaps.
- Pixels driven with pix_valid=1, sof=0 after reset -> no start, busy=0; a following sof frame behaves as the first test.
- sof re-asserted at (row 2, col 1) with a new ramp +100 -> no start from the old frame after the restart, no frame_done; 4 windows with values offset by 100.
- reset asserted at (row 2, col 2) concurrently with a valid pixel -> next cycle start=0, all outputs 0, busy=0; a subsequent full frame matches test 1.
- Two back-to-back frames (sof the cycle after the last pixel) -> 8 start pulses; frame_done pulses with the first pixel of frame 2 accepted. The second frame's windows contain no first-frame data.
